// File: rtl/reg_top.sv
// MiniMIPS multicycle register/decode block: IR, data/z registers, 32x32 register file,
// x/y operand latches and combinational instruction-field decode.
module reg_top (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr_in,
   input  logic [31:0] data_in,
   input  logic [31:0] alu_out,
   input  logic [21:0] ctrl_in,
   output logic [31:0] rs_data_out,
   output logic [31:0] rt_data_out,
   output logic [25:0] jta_out,
   output logic [31:0] imm_out,
   output logic [5:0]  op_out,
   output logic [5:0]  fn_out
);

   logic        ir_write;
   logic [1:0]  reg_dst;
   logic        reg_write;
   logic [1:0]  reg_in_src;
   logic        unused_ctrl;

   logic [31:0] ir_q, ir_d;
   logic [31:0] dr_q, dr_d;
   logic [31:0] z_q, z_d;
   logic [31:0] x_q, x_d;
   logic [31:0] y_q, y_d;
   logic [31:0] rf_q [32];
   logic [31:0] rf_d [32];

   logic [4:0]  wr_addr;
   logic [31:0] wr_data;

   assign ir_write    = ctrl_in[14];
   assign reg_dst     = ctrl_in[13:12];
   assign reg_write   = ctrl_in[11];
   assign reg_in_src  = ctrl_in[10:9];
   assign unused_ctrl = ^{ctrl_in[21:15], ctrl_in[8:0]};

   always_comb begin
      ir_d = ir_write ? instr_in : ir_q;
      dr_d = data_in;
      z_d  = alu_out;

      // x/y sample the pre-write register file, so a same-edge write is not forwarded
      x_d = rf_q[ir_q[25:21]];
      y_d = rf_q[ir_q[20:16]];

      case (reg_dst)
         2'b01:   wr_addr = ir_q[15:11];
         2'b10:   wr_addr = 5'd31;
         default: wr_addr = ir_q[20:16];
      endcase
      wr_data = (reg_in_src == 2'b00) ? dr_q : z_q;

      // register 0 is never written, so it stays at its reset value of zero
      rf_d = rf_q;
      if (reg_write && (wr_addr != 5'd0)) begin
         rf_d[wr_addr] = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ir_q <= '0;
         dr_q <= '0;
         z_q  <= '0;
         x_q  <= '0;
         y_q  <= '0;
         for (int unsigned i = 0; i < 32; i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         ir_q <= ir_d;
         dr_q <= dr_d;
         z_q  <= z_d;
         x_q  <= x_d;
         y_q  <= y_d;
         for (int unsigned i = 0; i < 32; i++) begin
            rf_q[i] <= rf_d[i];
         end
      end
   end

   assign rs_data_out = x_q;
   assign rt_data_out = y_q;
   assign op_out      = ir_q[31:26];
   assign fn_out      = ir_q[5:0];
   assign jta_out     = ir_q[25:0];
   assign imm_out     = {{16{ir_q[15]}}, ir_q[15:0]};

endmodule

// File: tb/tb_reg_top.sv
// Self-checking bench for reg_top: directed literal checks plus randomized traffic compared
// every cycle against a behavioural model of the register/decode block.
module tb_reg_top;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr_in;
   logic [31:0] data_in;
   logic [31:0] alu_out;
   logic [21:0] ctrl_in;
   logic [31:0] rs_data_out;
   logic [31:0] rt_data_out;
   logic [25:0] jta_out;
   logic [31:0] imm_out;
   logic [5:0]  op_out;
   logic [5:0]  fn_out;

   int checks   = 0;
   int failures = 0;
   bit model_ok = 1'b0;

   reg_top dut (
      .clk        (clk),
      .reset      (reset),
      .instr_in   (instr_in),
      .data_in    (data_in),
      .alu_out    (alu_out),
      .ctrl_in    (ctrl_in),
      .rs_data_out(rs_data_out),
      .rt_data_out(rt_data_out),
      .jta_out    (jta_out),
      .imm_out    (imm_out),
      .op_out     (op_out),
      .fn_out     (fn_out)
   );

   always #5 clk = ~clk;

   // behavioural model state
   logic [31:0] m_ir, m_dr, m_z, m_x, m_y;
   logic [31:0] m_rf [32];

   always @(posedge clk) begin
      int unsigned dst;
      logic [31:0] wd;
      if (reset) begin
         m_ir = 0; m_dr = 0; m_z = 0; m_x = 0; m_y = 0;
         for (int i = 0; i < 32; i++) m_rf[i] = 0;
      end else begin
         m_x = m_rf[(m_ir >> 21) % 32];
         m_y = m_rf[(m_ir >> 16) % 32];
         if (ctrl_in[11]) begin
            if (ctrl_in[13:12] == 2'd1)      dst = (m_ir >> 11) % 32;
            else if (ctrl_in[13:12] == 2'd2) dst = 31;
            else                              dst = (m_ir >> 16) % 32;
            wd = (ctrl_in[10:9] == 2'd0) ? m_dr : m_z;
            if (dst != 0) m_rf[dst] = wd;
         end
         m_dr = data_in;
         m_z  = alu_out;
         if (ctrl_in[14]) m_ir = instr_in;
      end
      model_ok = 1'b1;
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // continuous compare against the model, away from the active edge
   always @(negedge clk) begin
      if (model_ok) begin
         logic [31:0] e_imm;
         e_imm = m_ir & 32'h0000FFFF;
         if (m_ir & 32'h00008000) e_imm = e_imm + 32'hFFFF0000;
         cmp("model_rs",  rs_data_out, m_x);
         cmp("model_rt",  rt_data_out, m_y);
         cmp("model_op",  {26'd0, op_out}, m_ir >> 26);
         cmp("model_fn",  {26'd0, fn_out}, m_ir % 64);
         cmp("model_jta", {6'd0, jta_out}, m_ir % (1 << 26));
         cmp("model_imm", imm_out, e_imm);
      end
   end

   function automatic logic [21:0] cw(input bit irw, input bit [1:0] dst, input bit rw,
                                      input bit [1:0] src);
      return {7'd0, irw, dst, rw, src, 9'd0};
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #2;
   endtask

   task automatic drive(input logic [31:0] ins, input logic [31:0] din, input logic [31:0] alu,
                        input logic [21:0] c, input logic rst);
      instr_in = ins; data_in = din; alu_out = alu; ctrl_in = c; reset = rst;
   endtask

   initial begin
      drive(0, 0, 0, 0, 1'b1);
      @(negedge clk);
      tick(); tick();
      cmp("rst_rs",  rs_data_out, 0);
      cmp("rst_rt",  rt_data_out, 0);
      cmp("rst_op",  {26'd0, op_out}, 0);
      cmp("rst_fn",  {26'd0, fn_out}, 0);
      cmp("rst_jta", {6'd0, jta_out}, 0);
      cmp("rst_imm", imm_out, 0);
      drive(0, 0, 0, 0, 1'b0);
      tick();
      cmp("rel_rs", rs_data_out, 0);
      cmp("rel_rt", rt_data_out, 0);

      // load and hold IR
      drive(32'h8C010000, 0, 0, cw(1, 0, 0, 0), 0);
      tick();
      cmp("lw_op",  {26'd0, op_out}, 32'h23);
      cmp("lw_fn",  {26'd0, fn_out}, 0);
      cmp("lw_imm", imm_out, 0);
      cmp("lw_jta", {6'd0, jta_out}, 32'h0010000);
      drive(32'h8C020004, 0, 0, cw(0, 0, 0, 0), 0);
      tick();
      cmp("lw_rs", rs_data_out, 0);
      cmp("lw_rt", rt_data_out, 0);
      cmp("hold_op",  {26'd0, op_out}, 32'h23);
      cmp("hold_jta", {6'd0, jta_out}, 32'h0010000);
      cmp("hold_imm", imm_out, 0);

      drive(32'h00242825, 0, 0, cw(1, 0, 0, 0), 0);
      tick();
      cmp("or_op",  {26'd0, op_out}, 0);
      cmp("or_fn",  {26'd0, fn_out}, 32'h25);
      cmp("or_jta", {6'd0, jta_out}, 32'h0242825);
      cmp("or_imm", imm_out, 32'h00002825);

      // write r4 from data register, read back as rt
      drive(32'h00242825, 32'h12345678, 0, cw(0, 0, 0, 0), 0);
      tick();
      drive(32'h00242825, 32'h12345678, 0, cw(0, 2'b00, 1, 2'b00), 0);
      tick();
      drive(32'h00242825, 32'h12345678, 0, cw(0, 0, 0, 0), 0);
      tick();
      cmp("r4_rt", rt_data_out, 32'h12345678);

      // write r5 from z register via rd, read back as rs
      drive(32'h00242825, 0, 32'hCAFEF00D, cw(0, 0, 0, 0), 0);
      tick();
      drive(32'h00242825, 0, 32'hCAFEF00D, cw(0, 2'b01, 1, 2'b01), 0);
      tick();
      drive(32'h00A00000, 0, 0, cw(1, 0, 0, 0), 0);
      tick();
      drive(32'h00A00000, 0, 0, cw(0, 0, 0, 0), 0);
      tick();
      cmp("r5_rs", rs_data_out, 32'hCAFEF00D);

      // sign extension
      drive(32'h2006FFF9, 0, 0, cw(1, 0, 0, 0), 0);
      tick();
      cmp("imm_neg", imm_out, 32'hFFFFFFF9);
      drive(32'h20060007, 0, 0, cw(1, 0, 0, 0), 0);
      tick();
      cmp("imm_pos", imm_out, 32'h00000007);
      cmp("addi_op", {26'd0, op_out}, 32'h08);

      // writes to register 0 are discarded
      drive(32'h00000000, 32'hFFFFFFFF, 0, cw(1, 0, 0, 0), 0);
      tick();
      drive(32'h00000000, 32'hFFFFFFFF, 0, cw(0, 2'b00, 1, 2'b00), 0);
      tick();
      drive(32'h00000000, 0, 0, cw(0, 0, 0, 0), 0);
      tick(); tick();
      cmp("r0_rs", rs_data_out, 0);
      cmp("r0_rt", rt_data_out, 0);

      // reset dominates IRWrite and RegWrite; r4 and r5 are cleared
      drive(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, cw(1, 2'b01, 1, 2'b01), 1);
      tick();
      cmp("rst_mid_op",  {26'd0, op_out}, 0);
      cmp("rst_mid_imm", imm_out, 0);
      cmp("rst_mid_jta", {6'd0, jta_out}, 0);
      drive(32'h00A40000, 0, 0, cw(1, 0, 0, 0), 0);
      tick();
      drive(32'h00A40000, 0, 0, cw(0, 0, 0, 0), 0);
      tick();
      cmp("rst_mid_r5", rs_data_out, 0);
      cmp("rst_mid_r4", rt_data_out, 0);

      // randomized traffic, checked by the compare process every cycle
      for (int n = 0; n < 3000; n++) begin
         logic [21:0] c;
         c = 22'($urandom);
         c[14] = ($urandom_range(0, 3) == 0);
         drive($urandom, $urandom, $urandom, c, ($urandom_range(0, 199) == 0));
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_top.md
Name: reg_top

Overview:
Register/decode block of the multicycle MiniMIPS datapath. It holds the instruction register (IR), the memory data register, the ALU output register, the 32x32 general register file and the x/y operand latches. It exposes the decoded instruction fields (op, fn, jump target, extended immediate) and the rs/rt operands to the ALU and to the control unit. It is driven by the 22-bit control word from the multicycle controller.

Parameters:
None; widths are fixed: 32-bit data, 32 registers, 22-bit control word.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
instr_in  input  32  instruction word from memory
data_in  input  32  data word from memory
alu_out  input  32  ALU result
ctrl_in  input  22  control word; field map in Behaviour
rs_data_out  output  32  x latch (register file rs operand)
rt_data_out  output  32  y latch (register file rt operand)
jta_out  output  26  IR[25:0], jump target
imm_out  output  32  sign-extended IR[15:0]
op_out  output  6  IR[31:26]
fn_out  output  6  IR[5:0]

Behaviour:
- One clock (clk); reset is synchronous and active-high. All state updates on the rising edge of clk.
- ctrl_in map:
  - [14] IRWrite.
  - [13:12] RegDst: 00 selects rt=IR[20:16]; 01 selects rd=IR[15:11]; 10 selects register 31; 11 treated as 00.
  - [11] RegWrite.
  - [10:9] RegInSrc: 00 selects the data register; 01 selects the z register; 1x treated as 01.
  - All other bits are ignored by this block and reserved for other datapath blocks.
- Reset (reset=1 at a clock edge): IR, data register, z register, x, y and all 32 registers become 0. Reset overrides all other actions in that cycle, including IRWrite and RegWrite.
- IR: loads instr_in when IRWrite=1; otherwise holds its value.
- Data register: loads data_in every cycle.
- z register: loads alu_out every cycle.
- x/y latches: load regfile[IR[25:21]] and regfile[IR[20:16]] every cycle, using the IR value present before the edge.
- Register file:
  - Write: when RegWrite=1, the selected write data is written to the RegDst-selected register at the edge.
  - Register 0 reads as 0 always; writes to it are discarded.
  - Reads are combinational. A simultaneous write and read of the same register gives the old value to x/y.
- Combinational decode from the current IR:
  - op_out = IR[31:26], fn_out = IR[5:0].
  - jta_out = IR[25:0].
  - imm_out = {16 copies of IR[15], IR[15:0]}.
- Latency:
  - op_out, fn_out, imm_out and jta_out change immediately after the edge that loads IR.
  - rs_data_out and rt_data_out reflect a new IR one edge later.
  - Write data from data_in or alu_out reaches the register file two edges after it is applied: register latch, then write.
- No handshake. Control is purely level-sampled at each edge.

Test Plan:
- Reset held for 2 cycles with all inputs 0 -> every output 0; rs_data_out/rt_data_out stay 0 after release.
- Load and hold the IR:
  - instr_in=0x8C010000, IRWrite=1, one edge -> op_out=6'b100011, fn_out=0, imm_out=0, jta_out=0x0010000. One edge later, rs_data_out=rt_data_out=0.
  - Then IRWrite=0, instr_in=0x8C020004 -> all decode outputs unchanged.
- Load 0x00242825 with IRWrite=1 -> op_out=0, fn_out=6'b100101, jta_out=0x0242825, imm_out=0x00002825.
- Register write and readback:
  - IR=0x00242825, data_in=0x12345678 for 2 edges, RegDst=00, RegInSrc=00, RegWrite=1 on the second edge -> register 4 = 0x12345678.
  - Next edge with RegWrite=0 -> rt_data_out=0x12345678.
  - Repeat with RegDst=01 and alu_out=0xCAFEF00D, RegInSrc=01 -> register 5 written; reading it as rs gives 0xCAFEF00D.
- Immediate sign extension: IR=0x2006FFF9 -> imm_out=0xFFFFFFF9. IR=0x20060007 -> imm_out=0x00000007, op_out=6'b001000.
- Register 0 protection and reset mid-operation:
  - Write 0xFFFFFFFF with RegDst selecting rt=0 -> rs_data_out/rt_data_out reading register 0 remain 0.
  - Assert reset together with RegWrite=1 and IRWrite=1 -> no write occurs and IR=0.
